// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES-128 key-schedule definitions.
//   AES_NUM_ROUNDS : number of round-key transitions (10)
//   AES_RCON       : round constants for transitions idx -> idx+1, idx 0..9
//   kx_state_e     : key-expansion controller FSM states
//   rcon_at()      : bounded rcon lookup (0 outside the table)
//   sbox()         : AES S-box computed as GF(2^8) inverse plus affine map
package aes_pkg;

    localparam logic [3:0] AES_NUM_ROUNDS = 4'd10;

    localparam logic [7:0] AES_RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } kx_state_e;

    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        logic [7:0] r;
        if (idx < AES_NUM_ROUNDS) begin
            r = AES_RCON[idx];
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            p  = bb[0] ? (p ^ aa) : p;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0), then the affine step.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// key_round_step -- combinational AES-128 key-schedule step.
//   key      : current round key, word 0 in [127:96]
//   rcon     : round constant for this transition
//   next_key : following round key, same word order
module key_round_step (
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] rot_s;
    logic [31:0] sub_s;
    logic [31:0] t_s;
    logic [31:0] w0_s;
    logic [31:0] w1_s;
    logic [31:0] w2_s;
    logic [31:0] w3_s;

    rot_word u_rot (.word(key[31:0]), .result(rot_s));
    sub_word u_sub (.word(rot_s),     .result(sub_s));

    assign t_s  = sub_s ^ {rcon, 24'h000000};
    assign w0_s = key[127:96] ^ t_s;
    assign w1_s = key[95:64]  ^ w0_s;
    assign w2_s = key[63:32]  ^ w1_s;
    assign w3_s = key[31:0]   ^ w2_s;
    assign next_key = {w0_s, w1_s, w2_s, w3_s};
endmodule

// File: rtl/rot_word.sv
// rot_word -- AES RotWord: cyclic left rotation of a 32-bit word by one byte.
//   word   : input word  {a0,a1,a2,a3}
//   result : output word {a1,a2,a3,a0}
module rot_word (
    input  logic [31:0] word,
    output logic [31:0] result
);
    assign result = {word[23:0], word[31:24]};
endmodule

// File: rtl/sub_word.sv
// sub_word -- AES SubWord: S-box applied to each byte of a 32-bit word.
//   word   : input word
//   result : byte-wise substituted word
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);
    assign result = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};
endmodule

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl -- streams the 11 AES-128 round keys over a valid/ready port.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_start, i_key   : start request and cipher key (taken only from IDLE)
//   o_round_key/idx  : current round key and its index 0..10
//   o_rk_valid       : round key valid; i_rk_ready accepts it
//   o_busy, o_done   : expansion in progress / one-cycle completion pulse
// Optional build macro KEY_EXP_READBACK_EN adds i_rd_idx/o_rd_key, a registered
// readback of every round key presented during the last expansion.
module key_expansion_ctrl
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic         o_busy,
`ifdef KEY_EXP_READBACK_EN
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rd_key,
`endif
    output logic         o_done
);
    kx_state_e    state_r;
    kx_state_e    state_n_s;
    logic [127:0] key_r;
    logic [127:0] key_n_s;
    logic [3:0]   idx_r;
    logic [3:0]   idx_n_s;
    logic [7:0]   rcon_r;
    logic [7:0]   rcon_n_s;
    logic         valid_r;
    logic         valid_n_s;
    logic         busy_r;
    logic         busy_n_s;
    logic         done_r;
    logic         done_n_s;
    logic [127:0] step_key_s;

    key_round_step u_step (.key(key_r), .rcon(rcon_r), .next_key(step_key_s));

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_n_s = state_r;
        key_n_s   = key_r;
        idx_n_s   = idx_r;
        rcon_n_s  = rcon_r;
        valid_n_s = valid_r;
        busy_n_s  = busy_r;
        done_n_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    key_n_s   = i_key;
                    idx_n_s   = 4'd0;
                    rcon_n_s  = 8'h01;
                    valid_n_s = 1'b1;
                    busy_n_s  = 1'b1;
                    state_n_s = ST_EXPAND;
                end else begin
                    valid_n_s = 1'b0;
                    busy_n_s  = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (valid_r && i_rk_ready) begin
                    if (idx_r < AES_NUM_ROUNDS) begin
                        key_n_s  = step_key_s;
                        idx_n_s  = idx_r + 4'd1;
                        // rcon register always holds the constant for the pending step
                        rcon_n_s = rcon_at(idx_r + 4'd1);
                    end else begin
                        valid_n_s = 1'b0;
                        busy_n_s  = 1'b0;
                        done_n_s  = 1'b1;
                        state_n_s = ST_DONE;
                    end
                end else begin
                    state_n_s = ST_EXPAND;
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                valid_n_s = 1'b0;
                busy_n_s  = 1'b0;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            key_r   <= 128'h0;
            idx_r   <= 4'd0;
            rcon_r  <= 8'h01;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            key_r   <= key_n_s;
            idx_r   <= idx_n_s;
            rcon_r  <= rcon_n_s;
            valid_r <= valid_n_s;
            busy_r  <= busy_n_s;
            done_r  <= done_n_s;
        end
    end

    assign o_round_key = key_r;
    assign o_round_idx = idx_r;
    assign o_rk_valid  = valid_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

`ifdef KEY_EXP_READBACK_EN
    logic [127:0] rk_mem_r [0:10];
    logic [127:0] rd_key_r;
    logic         load_s;

    // A key is stored exactly when it is loaded into the key register.
    assign load_s = i_rst_n &&
                    (((state_r == ST_IDLE) && i_start) ||
                     ((state_r == ST_EXPAND) && valid_r && i_rk_ready &&
                      (idx_r < AES_NUM_ROUNDS)));

    // Round-key store; deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (load_s) begin
            rk_mem_r[idx_n_s] <= key_n_s;
        end else begin
            rk_mem_r[idx_n_s] <= rk_mem_r[idx_n_s];
        end
    end

    // Registered readback port; out-of-range indices read as zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_key_r <= 128'h0;
        end else if (i_rd_idx <= AES_NUM_ROUNDS) begin
            rd_key_r <= rk_mem_r[i_rd_idx];
        end else begin
            rd_key_r <= 128'h0;
        end
    end

    assign o_rd_key = rd_key_r;
`endif

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb_key_expansion_ctrl -- directed scoreboard bench for key_expansion_ctrl.
// Build with KEY_EXP_READBACK_EN defined to also exercise the readback port.
module tb_key_expansion_ctrl;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [127:0] i_key;
    logic [127:0] o_round_key;
    logic [3:0]   o_round_idx;
    logic         o_rk_valid;
    logic         i_rk_ready;
    logic         o_busy;
    logic         o_done;
`ifdef KEY_EXP_READBACK_EN
    logic [3:0]   i_rd_idx;
    logic [127:0] o_rd_key;
`endif

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] ref_a [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    always #5 clk = ~clk;

    key_expansion_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_key       (i_key),
        .o_round_key (o_round_key),
        .o_round_idx (o_round_idx),
        .o_rk_valid  (o_rk_valid),
        .i_rk_ready  (i_rk_ready),
        .o_busy      (o_busy),
`ifdef KEY_EXP_READBACK_EN
        .i_rd_idx    (i_rd_idx),
        .o_rd_key    (o_rd_key),
`endif
        .o_done      (o_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] k);
        i_key   = k;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic push_ref_a();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            e.idx = 4'(i);
            e.key = ref_a[i];
            e.chk = 1'b1;
            sb.push_back(e);
        end
    endtask

    // Consume round keys until o_done (bounded), checking against the scoreboard.
    task automatic drain(input bit rand_ready, input bit inject, input bit start_in_done,
                         input int done_cycle);
        int           cyc      = 1;
        int           dones    = 0;
        bit           stalled  = 1'b0;
        bit           injected = 1'b0;
        logic [127:0] held_key = 128'h0;
        logic [3:0]   held_idx = 4'd0;
        exp_t         e;
        while (dones == 0 && cyc <= 300) begin
            if (o_done) begin
                dones++;
                if (done_cycle != 0) check("done_cycle", 128'(cyc), 128'(done_cycle));
                check("busy_at_done", 128'(o_busy), 128'(1'b0));
                check("sb_empty_at_done", 128'(sb.size()), 128'(0));
                i_start    = start_in_done;
                i_key      = ~KEY_A;
                i_rk_ready = 1'b1;
            end else begin
                i_rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                i_start    = 1'b0;
                if (inject && !injected && o_rk_valid && o_round_idx == 4'd4) begin
                    i_start  = 1'b1;
                    i_key    = 128'h00112233445566778899aabbccddeeff;
                    injected = 1'b1;
                end
                if (o_rk_valid) begin
                    if (stalled) begin
                        check("stall_key", o_round_key, held_key);
                        check("stall_idx", 128'(o_round_idx), 128'(held_idx));
                    end
                    if (i_rk_ready) begin
                        if (sb.size() == 0) begin
                            check("sb_nonempty", 128'(sb.size()), 128'(1));
                        end else begin
                            e = sb.pop_front();
                            check("rk_idx", 128'(o_round_idx), 128'(e.idx));
                            if (e.chk) check("rk_key", o_round_key, e.key);
                            check("busy_while_valid", 128'(o_busy), 128'(1'b1));
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled  = 1'b1;
                        held_key = o_round_key;
                        held_idx = o_round_idx;
                    end
                end
            end
            step();
            cyc++;
        end
        i_start = 1'b0;
        check("done_seen_once", 128'(dones), 128'(1));
        check("done_one_cycle", 128'(o_done), 128'(1'b0));
        check("idle_valid", 128'(o_rk_valid), 128'(1'b0));
        check("idle_busy", 128'(o_busy), 128'(1'b0));
    endtask

    initial begin
        exp_t e;
        i_rst_n    = 1'b0;
        i_start    = 1'b1;
        i_key      = KEY_A;
        i_rk_ready = 1'b0;
`ifdef KEY_EXP_READBACK_EN
        i_rd_idx   = 4'd0;
`endif
        // Reset, with a start request held during reset.
        step();
        step();
        check("rst_valid", 128'(o_rk_valid), 128'(1'b0));
        check("rst_busy", 128'(o_busy), 128'(1'b0));
        check("rst_done", 128'(o_done), 128'(1'b0));
        check("rst_idx", 128'(o_round_idx), 128'(4'd0));
        check("rst_key", o_round_key, 128'h0);
        i_rst_n = 1'b1;
        i_start = 1'b0;
        step();
        check("post_rst_idle", 128'(o_rk_valid), 128'(1'b0));

        // Nominal expansion, ready always high, start attempted in the DONE cycle.
        push_ref_a();
        start(KEY_A);
        drain(1'b0, 1'b0, 1'b1, 12);
        step();
        check("start_in_done_ignored", 128'(o_rk_valid), 128'(1'b0));

`ifdef KEY_EXP_READBACK_EN
        i_rd_idx = 4'd1;
        step();
        check("rd_idx1", o_rd_key, ref_a[1]);
        i_rd_idx = 4'd10;
        step();
        check("rd_idx10", o_rd_key, ref_a[10]);
        i_rd_idx = 4'd15;
        step();
        check("rd_idx15", o_rd_key, 128'h0);
`endif

        // Random backpressure: same keys, stable while stalled.
        push_ref_a();
        start(KEY_A);
        drain(1'b1, 1'b0, 1'b0, 0);

        // Start pulse mid-expansion must not disturb anything.
        push_ref_a();
        start(KEY_A);
        drain(1'b0, 1'b1, 1'b0, 12);

`ifdef KEY_EXP_READBACK_EN
        i_rd_idx = 4'd0;
        step();
        check("rd_idx0_after_inject", o_rd_key, ref_a[0]);
`endif

        // Reset in the middle of an expansion at idx 6.
        push_ref_a();
        start(KEY_A);
        i_rk_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = sb.pop_front();
            check("pre_rst_idx", 128'(o_round_idx), 128'(e.idx));
            step();
        end
        check("at_idx6", 128'(o_round_idx), 128'(4'd6));
        i_rst_n = 1'b0;
        i_start = 1'b1;
        step();
        check("mid_rst_valid", 128'(o_rk_valid), 128'(1'b0));
        check("mid_rst_busy", 128'(o_busy), 128'(1'b0));
        check("mid_rst_done", 128'(o_done), 128'(1'b0));
        check("mid_rst_idx", 128'(o_round_idx), 128'(4'd0));
        check("mid_rst_key", o_round_key, 128'h0);
        i_rst_n = 1'b1;
        i_start = 1'b0;
        step();
        check("mid_rst_idle", 128'(o_busy), 128'(1'b0));
        sb.delete();

        // All-zero key after the mid-run reset.
        for (int i = 0; i < 11; i++) begin
            e.idx = 4'(i);
            e.chk = (i < 2);
            e.key = (i == 0) ? 128'h0 : 128'h62636363626363636263636362636363;
            sb.push_back(e);
        end
        start(128'h0);
        drain(1'b0, 1'b0, 1'b0, 12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port i_start, input, 1: single-cycle request to begin expansion of i_key.
REQ-004 SHALL have port i_key, input, 128: AES-128 cipher key, word 0 in bits [127:96]; sampled only on an accepted start.
REQ-005 SHALL have port o_round_key, output, 128: current round key, same word order as i_key.
REQ-006 SHALL have port o_round_idx, output, 4: index 0..10 of o_round_key.
REQ-007 SHALL have port o_rk_valid, output, 1: o_round_key/o_round_idx valid.
REQ-008 SHALL have port i_rk_ready, input, 1: consumer accepts the round key when o_rk_valid and i_rk_ready are both high.
REQ-009 SHALL have port o_busy, output, 1: high from accepted start until o_done.
REQ-010 SHALL have port o_done, output, 1: one-cycle pulse after round key 10 is accepted.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-012 IDLE + i_start=1 SHALL load i_key into the key register, set idx=0, assert o_rk_valid and o_busy next cycle, go to EXPAND.
REQ-013 EXPAND with handshake and idx<10 SHALL replace the key register with next round key, idx+1, rcon advance, o_rk_valid stays high.
REQ-014 Next round key SHALL be t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2' (all bitwise XOR, 32-bit words).
REQ-015 rcon SHALL follow 01,02,04,08,10,20,40,80,1B,36 for idx 0..9 (rcon for transition idx->idx+1).
REQ-016 EXPAND with o_rk_valid=1 and i_rk_ready=0 SHALL hold o_round_key, o_round_idx stable (stall, no limit).
REQ-017 EXPAND with handshake at idx=10 SHALL deassert o_rk_valid next cycle and go to DONE.
REQ-018 DONE SHALL assert o_done for exactly one cycle, deassert o_busy, return to IDLE.
REQ-019 i_start while o_busy=1 SHALL be ignored, no effect on state or key.
REQ-020 i_start in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-021 Throughput SHALL be one round key per cycle with i_rk_ready held high: 11 valid cycles, o_done on the cycle after the last.

Reset
REQ-022 i_rst_n=0 at a clock edge SHALL force IDLE, o_rk_valid=0, o_busy=0, o_done=0, o_round_idx=0, o_round_key=0, rcon=01, from any state including mid-expansion.
REQ-023 i_start coincident with i_rst_n=0 SHALL be ignored.

Configuration
REQ-024 With KEY_EXP_READBACK_EN defined SHALL add i_rd_idx (input, 4) and o_rd_key (output, 128), and store each round key into an 11x128 array as it is first presented.
REQ-025 With KEY_EXP_READBACK_EN, o_rd_key SHALL equal the stored key for i_rd_idx one cycle later (registered); i_rd_idx>10 SHALL return 0; the array is not cleared by reset, content before first write is don't-care.
REQ-026 Without KEY_EXP_READBACK_EN, ports i_rd_idx/o_rd_key and the array SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared package aes_pkg SHALL hold AES_NUM_ROUNDS=10, the 10-entry rcon table, and the FSM state typedef.
REQ-028 Sub-module key_round_step (combinational: 128-bit key + 8-bit rcon -> next 128-bit key) SHALL contain REQ-014, instantiating existing rot_word and sub_word.

Verification
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, ready=1: idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; o_done on cycle 12 after start.
REQ-030 Same key, i_rk_ready toggled pseudo-randomly: identical 11-key sequence, each key stable while stalled, o_done exactly once.
REQ-031 i_start pulsed at idx 4 with different key: sequence and idx10 key unchanged from REQ-029.
REQ-032 i_rst_n=0 at idx 6: next cycle all outputs zero, IDLE; subsequent start with key 000...0 yields idx1 = 62636363626363636263636362636363.
REQ-033 KEY_EXP_READBACK_EN build after REQ-029: i_rd_idx=1 -> o_rd_key=a0fafe17...6c7605 next cycle; i_rd_idx=15 -> 0.
